mem_io_responder: RTL and testbench



---
 rtl/mem_io_responder_pkg.sv | 17 +
 rtl/mem_io_responder_sync_fifo.sv | 64 ++++++
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants for mem_io_responder: MMIO window decode and bus op encodings.
package mem_io_responder_pkg;

    localparam logic [31:0] IO_BASE       = 32'h30000;
    localparam logic [2:0]  IO_DATA_OFS   = 3'd0;
    localparam logic [2:0]  IO_STATUS_OFS = 3'd4;

    localparam int unsigned IO_SEL_HI     = 17;
    localparam int unsigned IO_SEL_LO     = 16;
    localparam logic [1:0]  IO_SEL_MATCH  = IO_BASE[IO_SEL_HI:IO_SEL_LO];

    typedef enum logic {
        BUS_READ  = 1'b0,
        BUS_WRITE = 1'b1
    } bus_op_e;

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Synchronous FIFO with same-cycle push/pop; a push into a full FIFO is
// taken when a pop in the same cycle frees a slot. DEPTH must be a power of two.
module sync_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Head reads as zero when empty so storage contents never leak out.
    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_COUNT);
    assign head       = empty ? '0 : mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory-bus responder: on-chip RAM plus an MMIO window with a TX FIFO
// toward the UART. Define IO_RX_EN to add the RX FIFO, offset-0 read pop and status bit 0.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 8,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_wr,
    input  logic [31:0] ram_addr,
    input  logic [7:0]  ram_wdata,
    output logic [7:0]  ram_rdata,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_overflow
);

    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam logic [TX_CW-1:0] NEAR_FULL = TX_CW'(TX_DEPTH - FULL_MARGIN);

    logic [7:0] mem [2**ADDR_WIDTH];

    logic             io_sel, is_write, ram_we;
    logic [2:0]       io_ofs;
    logic             tx_push_req, tx_pop, tx_full, tx_empty;
    logic [TX_CW-1:0] tx_count_next, unused_tx_count;
    logic             rx_nonempty;
    logic [7:0]       rx_head;
    logic [7:0]       ram_rdata_d, ram_rdata_q;
    logic             io_buffer_full_d, io_buffer_full_q;
    logic             tx_overflow_d, tx_overflow_q;
    logic [31:18]     unused_addr_hi;

    assign unused_addr_hi = ram_addr[31:18];

    always_comb begin
        io_sel      = (ram_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_MATCH);
        is_write    = (bus_op_e'(ram_wr) == BUS_WRITE);
        io_ofs      = ram_addr[2:0];
        ram_we      = is_write && !io_sel;
        tx_push_req = is_write && io_sel && (io_ofs == IO_DATA_OFS);
        tx_pop      = !tx_empty && tx_ready;

        // Computed from next count so the controller can issue one more write
        // in the cycle after it samples the flag low.
        io_buffer_full_d = (tx_count_next >= NEAR_FULL);
        tx_overflow_d    = tx_overflow_q || (tx_push_req && tx_full && !tx_pop);

        ram_rdata_d = '0;
        if (!is_write) begin
            if (!io_sel) begin
                ram_rdata_d = mem[ram_addr[ADDR_WIDTH-1:0]];
            end else if (io_ofs == IO_DATA_OFS) begin
                ram_rdata_d = rx_head;
            end else if (io_ofs == IO_STATUS_OFS) begin
                ram_rdata_d = {6'b0, io_buffer_full_q, rx_nonempty};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[ADDR_WIDTH-1:0]] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rdata_q      <= '0;
            io_buffer_full_q <= 1'b0;
            tx_overflow_q    <= 1'b0;
        end else begin
            ram_rdata_q      <= ram_rdata_d;
            io_buffer_full_q <= io_buffer_full_d;
            tx_overflow_q    <= tx_overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tx_push_req),
        .wdata      (ram_wdata),
        .pop        (tx_pop),
        .head       (tx_data),
        .full       (tx_full),
        .empty      (tx_empty),
        .count      (unused_tx_count),
        .count_next (tx_count_next)
    );

`ifdef IO_RX_EN
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

    logic             rx_full, rx_empty, rx_rd_req;
    logic [RX_CW-1:0] unused_rx_count, unused_rx_count_next;

    assign rx_rd_req = io_sel && !is_write && (io_ofs == IO_DATA_OFS);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (rx_valid && !rx_full),
        .wdata      (rx_data),
        .pop        (rx_rd_req),
        .head       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .count      (unused_rx_count),
        .count_next (unused_rx_count_next)
    );

    assign rx_ready    = !rx_full;
    assign rx_nonempty = !rx_empty;
`else
    logic [$clog2(RX_DEPTH)+8:0] unused_rx_in;

    assign unused_rx_in = {{$clog2(RX_DEPTH){1'b0}}, rx_valid, rx_data};
    assign rx_ready     = 1'b0;
    assign rx_nonempty  = 1'b0;
    assign rx_head      = '0;
`endif

    assign ram_rdata      = ram_rdata_q;
    assign io_buffer_full = io_buffer_full_q;
    assign tx_valid       = !tx_empty;
    assign tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: RAM/MMIO vector table, then TX drain,
// full-margin, async reset, simultaneous push/pop and RX sequences.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_wr;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] rd_exp_q [$];
    logic [7:0] tx_exp_q [$];

`ifdef IO_RX_EN
    localparam logic RX_READY_IDLE = 1'b1;
`else
    localparam logic RX_READY_IDLE = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_txv;
    } vec_t;

    vec_t vecs [20];

    mem_io_responder #(
        .ADDR_WIDTH  (17),
        .TX_DEPTH    (16),
        .RX_DEPTH    (8),
        .FULL_MARGIN (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_wr         (ram_wr),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // One bus cycle; the expected read byte is queued and checked after the edge.
    task automatic bus_op(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp, input string name);
        logic [7:0] e;
        ram_wr    = wr;
        ram_addr  = addr;
        ram_wdata = wd;
        rd_exp_q.push_back(exp);
        @(posedge clk);
        #1;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        e = rd_exp_q.pop_front();
        check(name, ram_rdata, e);
    endtask

    task automatic tx_write(input logic [7:0] b, input bit accept);
        bus_op(1'b1, 32'h30000, b, 8'h00, "tx write rdata");
        if (accept) tx_exp_q.push_back(b);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic drain_check(input string name);
        int unsigned guard;
        logic [7:0]  e;
        guard    = 0;
        tx_ready = 1'b1;
        while (tx_valid && guard < 64) begin
            if (tx_exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s extra: got 0x%02h, expected no byte", name, tx_data);
            end else begin
                e = tx_exp_q.pop_front();
                check({name, " byte"}, tx_data, e);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        tx_ready = 1'b0;
        check({name, " tx_valid end"}, {7'b0, tx_valid}, 8'h00);
        check({name, " missing"}, 8'(tx_exp_q.size()), 8'h00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        rst = 1'b1; ram_wr = 1'b0; ram_addr = '0; ram_wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

        vecs = '{
            '{1'b1, 32'h00124,    8'h11, 8'h00, 1'b0},
            '{1'b1, 32'h00123,    8'h5A, 8'h00, 1'b0},
            '{1'b0, 32'h00123,    8'h00, 8'h5A, 1'b0},
            '{1'b0, 32'h00124,    8'h00, 8'h11, 1'b0},
            '{1'b1, 32'h00000,    8'hC3, 8'h00, 1'b0},
            '{1'b0, 32'h00000,    8'h00, 8'hC3, 1'b0},
            '{1'b1, 32'h10123,    8'h66, 8'h00, 1'b0},
            '{1'b0, 32'h10123,    8'h00, 8'h66, 1'b0},
            '{1'b0, 32'h00123,    8'h00, 8'h5A, 1'b0},
            '{1'b0, 32'h40123,    8'h00, 8'h5A, 1'b0},
            '{1'b0, 32'hFFFC0123, 8'h00, 8'h5A, 1'b0},
            '{1'b1, 32'h1FFFF,    8'hA5, 8'h00, 1'b0},
            '{1'b0, 32'h1FFFF,    8'h00, 8'hA5, 1'b0},
            '{1'b0, 32'h20123,    8'h00, 8'h5A, 1'b0},
            '{1'b0, 32'h30004,    8'h00, 8'h00, 1'b0},
            '{1'b0, 32'h30002,    8'h00, 8'h00, 1'b0},
            '{1'b0, 32'h30000,    8'h00, 8'h00, 1'b0},
            '{1'b1, 32'h30004,    8'h77, 8'h00, 1'b0},
            '{1'b1, 32'h30003,    8'h78, 8'h00, 1'b0},
            '{1'b0, 32'h30004,    8'h00, 8'h00, 1'b0}
        };

        #12;
        check("reset ram_rdata", ram_rdata, 8'h00);
        check("reset io_buffer_full", {7'b0, io_buffer_full}, 8'h00);
        check("reset tx_valid", {7'b0, tx_valid}, 8'h00);
        check("reset tx_data", tx_data, 8'h00);
        check("reset rx_ready", {7'b0, rx_ready}, {7'b0, RX_READY_IDLE});
        check("reset tx_overflow", {7'b0, tx_overflow}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                   $sformatf("vec%0d rdata", i));
            check($sformatf("vec%0d tx_valid", i), {7'b0, tx_valid}, {7'b0, vecs[i].exp_txv});
        end

        // TX drain of "Hi"
        tx_write(8'h48, 1'b1);
        tx_write(8'h69, 1'b1);
        check("hi tx_valid", {7'b0, tx_valid}, 8'h01);
        check("hi tx_data", tx_data, 8'h48);
        drain_check("drain hi");

        // Full margin and overflow
        for (int i = 1; i <= 17; i++) begin
            tx_write(8'(8'h80 + i), (i <= 16));
            if (i == 13) check("margin ibf@13", {7'b0, io_buffer_full}, 8'h00);
            if (i == 14) check("margin ibf@14", {7'b0, io_buffer_full}, 8'h01);
            if (i == 16) check("margin ovf@16", {7'b0, tx_overflow}, 8'h00);
            if (i == 17) check("margin ovf@17", {7'b0, tx_overflow}, 8'h01);
        end
        bus_op(1'b0, 32'h30004, 8'h00, 8'h02, "margin status");
        drain_check("drain full");
        check("margin ibf after drain", {7'b0, io_buffer_full}, 8'h00);
        check("margin ovf sticky", {7'b0, tx_overflow}, 8'h01);

        // Async reset while the TX FIFO is draining
        for (int i = 0; i < 16; i++) tx_write(8'(8'hC0 + i), 1'b1);
        check("rst pre ibf", {7'b0, io_buffer_full}, 8'h01);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst pre tx_data", tx_data, 8'hC1);
        #2 rst = 1'b1;
        #1;
        check("async rst tx_valid", {7'b0, tx_valid}, 8'h00);
        check("async rst ibf", {7'b0, io_buffer_full}, 8'h00);
        check("async rst ovf", {7'b0, tx_overflow}, 8'h00);
        check("async rst tx_data", tx_data, 8'h00);
        tx_exp_q.delete();
        tx_ready = 1'b0;
        #1 rst = 1'b0;
        bus_op(1'b0, 32'h30004, 8'h00, 8'h00, "post rst status");
        check("post rst tx_valid", {7'b0, tx_valid}, 8'h00);

        // Simultaneous push and pop on a full TX FIFO
        for (int i = 1; i <= 16; i++) tx_write(8'(8'h10 + i), 1'b1);
        check("simul pre ibf", {7'b0, io_buffer_full}, 8'h01);
        e = tx_exp_q.pop_front();
        check("simul head", tx_data, e);
        tx_exp_q.push_back(8'hEE);
        tx_ready = 1'b1;
        bus_op(1'b1, 32'h30000, 8'hEE, 8'h00, "simul write rdata");
        check("simul ovf", {7'b0, tx_overflow}, 8'h00);
        check("simul ibf", {7'b0, io_buffer_full}, 8'h01);
        drain_check("drain simul");

`ifdef IO_RX_EN
        rx_push(8'h41);
        rx_push(8'h42);
        bus_op(1'b0, 32'h30004, 8'h00, 8'h01, "rx status");
        bus_op(1'b0, 32'h30000, 8'h00, 8'h41, "rx pop 1");
        bus_op(1'b0, 32'h30000, 8'h00, 8'h42, "rx pop 2");
        bus_op(1'b0, 32'h30000, 8'h00, 8'h00, "rx pop empty");
        bus_op(1'b0, 32'h30004, 8'h00, 8'h00, "rx status empty");
        for (int i = 1; i <= 9; i++) begin
            rx_push(8'(8'h60 + i));
            check($sformatf("rx_ready after push %0d", i), {7'b0, rx_ready}, {7'b0, (i < 8)});
        end
        bus_op(1'b0, 32'h30004, 8'h00, 8'h01, "rx status full");
        for (int i = 1; i <= 8; i++) begin
            bus_op(1'b0, 32'h30000, 8'h00, 8'(8'h60 + i), $sformatf("rx fill pop %0d", i));
            if (i == 1) check("rx_ready after pop", {7'b0, rx_ready}, 8'h01);
        end
        bus_op(1'b0, 32'h30000, 8'h00, 8'h00, "rx ninth dropped");
        rx_push(8'hA1);
        rx_valid = 1'b1;
        rx_data  = 8'hA2;
        bus_op(1'b0, 32'h30000, 8'h00, 8'hA1, "rx simul pop");
        rx_valid = 1'b0;
        bus_op(1'b0, 32'h30000, 8'h00, 8'hA2, "rx simul pushed");
        bus_op(1'b0, 32'h30000, 8'h00, 8'h00, "rx simul empty");
`else
        rx_push(8'h55);
        check("norx rx_ready", {7'b0, rx_ready}, 8'h00);
        bus_op(1'b0, 32'h30000, 8'h00, 8'h00, "norx data read");
        bus_op(1'b0, 32'h30004, 8'h00, 8'h00, "norx status");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
